// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the external memory path: SRAM controller state
// encoding, bus data width, default wait-state counts (also used by the SoC
// top) and a helper that sizes the wait-state counter.
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_DATA_W          = 16;
  localparam int SRAM_READ_WAIT_DEF  = 2;
  localparam int SRAM_WRITE_WAIT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ACCESS = 3'd1,
    ST_WR_SETUP  = 3'd2,
    ST_WR_PULSE  = 3'd3,
    ST_WR_HOLD   = 3'd4,
    ST_DONE      = 3'd5
  } sram_state_t;

  // Counter width able to hold the larger of the two wait-state loads.
  function automatic int wait_cnt_w(input int rd_wait, input int wr_wait);
    return $clog2((rd_wait > wr_wait) ? rd_wait : wr_wait) + 1;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_if
// CPU-side request handshake of the external memory interface.
//   addr_i     : word address from the master
//   re_i/we_i  : read / write request, held until needWait_o is seen low
//   needWait_o : access in progress, master keeps its request stable
// The bidirectional data bus stays a plain inout port on the controller.
// ---------------------------------------------------------------------------
interface sram_ctrl_if #(
  parameter int ADDR_W = 18
) ();

  logic [ADDR_W-1:0] addr_i;
  logic              re_i;
  logic              we_i;
  logic              needWait_o;

  modport master (output addr_i, output re_i, output we_i, input needWait_o);
  modport slave  (input addr_i, input re_i, input we_i, output needWait_o);

endinterface

// File: rtl/sram_wait_counter.sv
// ---------------------------------------------------------------------------
// sram_wait_counter
// Loadable down-counter for memory wait states.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load_i       : load load_val_i (has priority over decrement)
//   load_val_i   : value to load
//   dec_i        : decrement by one; saturates at zero
//   zero_o       : counter currently holds zero
// ---------------------------------------------------------------------------
module sram_wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// Asynchronous 16-bit SRAM controller. Converts the re/we/needWait request
// handshake into sequenced ce_n/oe_n/we_n strobes with configurable read and
// write wait states. Read data is returned from a capture register.
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus            : request handshake (sram_ctrl_if.slave)
//   data_io        : CPU data bus; sampled on writes, driven in DONE of a read
//   sram_addr_o    : registered SRAM word address
//   sram_data_io   : SRAM data bus, driven only during write states
//   sram_ce_n/oe_n/we_n/ub_n/lb_n : registered SRAM strobes
// ---------------------------------------------------------------------------
module sram_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int READ_WAIT  = SRAM_READ_WAIT_DEF,
  parameter int WRITE_WAIT = SRAM_WRITE_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_ctrl_if.slave            bus,
  inout  wire  [MEM_DATA_W-1:0] data_io,
  output logic [ADDR_W-1:0]     sram_addr_o,
  inout  wire  [MEM_DATA_W-1:0] sram_data_io,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ub_n,
  output logic                  sram_lb_n
);

  localparam int CNT_W = wait_cnt_w(READ_WAIT, WRITE_WAIT);

  sram_state_t             state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [MEM_DATA_W-1:0]   wdata_q, wdata_d;
  logic [MEM_DATA_W-1:0]   rdata_q, rdata_d;
  logic                    is_read_q, is_read_d;
  logic                    ce_n_q, oe_n_q, we_n_q, drv_q;
  logic                    cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]        cnt_val;

  sram_wait_counter #(.W(CNT_W)) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    is_read_d = is_read_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;
    case (state_q)
      ST_IDLE: begin
        // Write wins when both requests are present.
        if (bus.we_i) begin
          addr_d    = bus.addr_i;
          wdata_d   = data_io;
          is_read_d = 1'b0;
          state_d   = ST_WR_SETUP;
        end else if (bus.re_i) begin
          addr_d    = bus.addr_i;
          is_read_d = 1'b1;
          cnt_load  = 1'b1;
          cnt_val   = CNT_W'(READ_WAIT - 1);
          state_d   = ST_RD_ACCESS;
        end
      end
      ST_RD_ACCESS: begin
        if (cnt_zero) begin
          rdata_d = sram_data_io;
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(WRITE_WAIT - 1);
        state_d  = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_HOLD: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so the pins change only on
  // clock edges and line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      is_read_q <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      drv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      is_read_q <= is_read_d;
      ce_n_q    <= !(state_d inside {ST_RD_ACCESS, ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
      oe_n_q    <= (state_d != ST_RD_ACCESS);
      we_n_q    <= (state_d != ST_WR_PULSE);
      drv_q     <= (state_d inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
    end
  end

  assign bus.needWait_o = (bus.re_i | bus.we_i) & (state_q != ST_DONE);

  // Read data goes out only in DONE of an access that really was a read, so a
  // read request held alongside a winning write never gets stale data.
  assign data_io      = (state_q == ST_DONE && bus.re_i && is_read_q) ? rdata_q
                                                                      : {MEM_DATA_W{1'bz}};
  assign sram_data_io = drv_q ? wdata_q : {MEM_DATA_W{1'bz}};

  assign sram_addr_o = addr_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_ub_n   = ce_n_q;
  assign sram_lb_n   = ce_n_q;

endmodule
